// File: rtl/vga_timing_pkg.sv
// Shared constants and helpers for the raster timing generator: standard mode
// geometries, line/frame totals and sync-window arithmetic.
package vga_timing_pkg;

    // 640x480@60, 25 MHz pixel clock (CLK_DIV=2 from 50 MHz), both syncs active-low
    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FRONT  = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BACK   = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FRONT  = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BACK   = 33;
    localparam int unsigned VGA640_CLK_DIV  = 2;

    // 800x600@72, 50 MHz pixel clock (CLK_DIV=1), both syncs active-high
    localparam int unsigned SVGA800_H_ACTIVE = 800;
    localparam int unsigned SVGA800_H_FRONT  = 56;
    localparam int unsigned SVGA800_H_SYNC   = 120;
    localparam int unsigned SVGA800_H_BACK   = 64;
    localparam int unsigned SVGA800_V_ACTIVE = 600;
    localparam int unsigned SVGA800_V_FRONT  = 37;
    localparam int unsigned SVGA800_V_SYNC   = 6;
    localparam int unsigned SVGA800_V_BACK   = 23;
    localparam int unsigned SVGA800_CLK_DIV  = 1;

    function automatic int unsigned h_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned v_total(input int unsigned active, input int unsigned front,
                                            input int unsigned sync, input int unsigned back);
        return active + front + sync + back;
    endfunction

    function automatic int unsigned sync_first(input int unsigned active, input int unsigned front);
        return active + front;
    endfunction

    function automatic int unsigned sync_last(input int unsigned active, input int unsigned front,
                                              input int unsigned sync);
        return active + front + sync - 1;
    endfunction

    function automatic logic in_sync(input int unsigned cnt, input int unsigned active,
                                     input int unsigned front, input int unsigned sync);
        return (cnt >= sync_first(active, front)) && (cnt <= sync_last(active, front, sync));
    endfunction

endpackage

// File: rtl/vga_timing_gen_axis_counter.sv
// One raster axis: a modulo-TOTAL counter with synchronous clear and an advance strobe.
// Wrap flags the last count so the caller can chain the next axis off it.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned CW    = 11
) (
    input  logic          Clk50,
    input  logic          Reset_n,
    input  logic          Clr,
    input  logic          Adv,
    output logic [CW-1:0] Cnt,
    output logic          Wrap
);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign Wrap = (cnt_q == CW'(TOTAL - 1));
    assign Cnt  = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (Clr) begin
            cnt_d = '0;
        end else if (Adv) begin
            cnt_d = Wrap ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Programmable raster timing generator: pixel-clock divider, H/V counters, registered
// sync/active/fetch-address outputs and a completed-frame counter.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = VGA640_H_ACTIVE,
    parameter int unsigned H_FRONT  = VGA640_H_FRONT,
    parameter int unsigned H_SYNC   = VGA640_H_SYNC,
    parameter int unsigned H_BACK   = VGA640_H_BACK,
    parameter int unsigned V_ACTIVE = VGA640_V_ACTIVE,
    parameter int unsigned V_FRONT  = VGA640_V_FRONT,
    parameter int unsigned V_SYNC   = VGA640_V_SYNC,
    parameter int unsigned V_BACK   = VGA640_V_BACK,
    parameter int unsigned H_POL    = 0,
    parameter int unsigned V_POL    = 0,
    parameter int unsigned CLK_DIV  = VGA640_CLK_DIV,
    parameter int unsigned LEAD     = 1,
    parameter int unsigned CW       = 11,
    parameter int unsigned FW       = 16
) (
    input  logic          Clk50,
    input  logic          Reset_n,
    input  logic          Enable,
    output logic          PixEn,
    output logic          HSync,
    output logic          VSync,
    output logic          Active,
    output logic [CW-1:0] Col,
    output logic [CW-1:0] Row,
    output logic          LineStart,
    output logic          FrameStart,
    output logic [FW-1:0] FrameCount
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);
    localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] COL_IDLE = CW'(LEAD % H_TOTAL);
    localparam logic H_ON  = (H_POL != 0);
    localparam logic H_OFF = ~H_ON;
    localparam logic V_ON  = (V_POL != 0);
    localparam logic V_OFF = ~V_ON;

    logic [DW-1:0] div_q, div_d;
    logic          tick;
    logic [CW-1:0] h_cnt, v_cnt;
    logic          h_wrap, v_wrap, frame_wrap;
    logic [CW:0]   lead_sum, lead_sub;
    logic          col_wraps;

    logic          pix_en_q, pix_en_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          active_q, active_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    logic          line_start_q, line_start_d;
    logic          frame_start_q, frame_start_d;
    logic [FW-1:0] frame_count_q, frame_count_d;

    assign tick       = Enable && (div_q == DW'(CLK_DIV - 1));
    assign frame_wrap = tick && h_wrap && v_wrap;

    always_comb begin
        div_d = '0;
        if (Enable && !tick) begin
            div_d = div_q + 1'b1;
        end
    end

    vga_axis_counter #(.TOTAL(H_TOTAL), .CW(CW)) u_h_axis (
        .Clk50  (Clk50),
        .Reset_n(Reset_n),
        .Clr    (!Enable),
        .Adv    (tick),
        .Cnt    (h_cnt),
        .Wrap   (h_wrap)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .CW(CW)) u_v_axis (
        .Clk50  (Clk50),
        .Reset_n(Reset_n),
        .Clr    (!Enable),
        .Adv    (tick && h_wrap),
        .Cnt    (v_cnt),
        .Wrap   (v_wrap)
    );

    // Lead add is one bit wider than the counters so the wrap compare cannot overflow
    assign lead_sum  = {1'b0, h_cnt} + (CW+1)'(LEAD);
    assign lead_sub  = lead_sum - (CW+1)'(H_TOTAL);
    assign col_wraps = (lead_sum >= (CW+1)'(H_TOTAL));

    always_comb begin
        pix_en_d      = 1'b0;
        hsync_d       = H_OFF;
        vsync_d       = V_OFF;
        active_d      = 1'b0;
        col_d         = COL_IDLE;
        row_d         = '0;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        frame_count_d = frame_count_q;
        if (Enable) begin
            pix_en_d      = tick;
            line_start_d  = tick && h_wrap;
            frame_start_d = frame_wrap;
            active_d      = (h_cnt < CW'(H_ACTIVE)) && (v_cnt < CW'(V_ACTIVE));
            hsync_d       = in_sync(32'(h_cnt), H_ACTIVE, H_FRONT, H_SYNC) ? H_ON : H_OFF;
            vsync_d       = in_sync(32'(v_cnt), V_ACTIVE, V_FRONT, V_SYNC) ? V_ON : V_OFF;
            if (col_wraps) begin
                col_d = lead_sub[CW-1:0];
                row_d = v_wrap ? '0 : v_cnt + 1'b1;
            end else begin
                col_d = lead_sum[CW-1:0];
                row_d = v_cnt;
            end
            if (frame_wrap) begin
                frame_count_d = frame_count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge Clk50 or negedge Reset_n) begin
        if (!Reset_n) begin
            div_q         <= '0;
            pix_en_q      <= 1'b0;
            hsync_q       <= H_OFF;
            vsync_q       <= V_OFF;
            active_q      <= 1'b0;
            col_q         <= COL_IDLE;
            row_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_count_q <= '0;
        end else begin
            div_q         <= div_d;
            pix_en_q      <= pix_en_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            active_q      <= active_d;
            col_q         <= col_d;
            row_q         <= row_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign PixEn      = pix_en_q;
    assign HSync      = hsync_q;
    assign VSync      = vsync_q;
    assign Active     = active_q;
    assign Col        = col_q;
    assign Row        = row_q;
    assign LineStart  = line_start_q;
    assign FrameStart = frame_start_q;
    assign FrameCount = frame_count_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: a pixel-index reference model checks two small-mode instances every
// cycle, plus a vector table and directed sequences, and a default-mode instance for line timing.
module tb_vga_timing_gen;

    localparam int S_HA = 8, S_HF = 2, S_HS = 2, S_HB = 2;
    localparam int S_VA = 4, S_VF = 1, S_VS = 1, S_VB = 1;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;
    localparam int S_FT = S_HT * S_VT;

    typedef struct packed {
        logic        pixEn;
        logic        hSync;
        logic        vSync;
        logic        active;
        logic        lineStart;
        logic        frameStart;
        logic [10:0] col;
        logic [10:0] row;
        logic [15:0] frameCount;
    } outVec_t;

    typedef struct packed {
        logic        en;
        logic        pixEn;
        logic        active;
        logic        hSync;
        logic        lineStart;
        logic [10:0] col;
        logic [10:0] row;
    } tableVec_t;

    logic clock = 1'b0;
    logic resetNS = 1'b0, enableS = 1'b0;
    logic resetND = 1'b0, enableD = 1'b0;

    logic sPix, sHs, sVs, sAct, sLs, sFs;
    logic [10:0] sCol, sRow;
    logic [15:0] sFc;
    logic tPix, tHs, tVs, tAct, tLs, tFs;
    logic [10:0] tCol, tRow;
    logic [15:0] tFc;
    logic dPix, dHs, dVs, dAct, dLs, dFs;
    logic [10:0] dCol, dRow;
    logic [15:0] dFc;
    outVec_t outS, outT, outD;

    int checkCount = 0;
    int passCount  = 0;
    bit modelOn    = 1'b0;
    int kS = 0, fcS = 0, kT = 0, fcT = 0;

    always #5 clock = ~clock;

    vga_timing_gen #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                     .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                     .CLK_DIV(1), .LEAD(3)) dutS (
        .Clk50(clock), .Reset_n(resetNS), .Enable(enableS), .PixEn(sPix), .HSync(sHs),
        .VSync(sVs), .Active(sAct), .Col(sCol), .Row(sRow), .LineStart(sLs),
        .FrameStart(sFs), .FrameCount(sFc));

    vga_timing_gen #(.H_ACTIVE(S_HA), .H_FRONT(S_HF), .H_SYNC(S_HS), .H_BACK(S_HB),
                     .V_ACTIVE(S_VA), .V_FRONT(S_VF), .V_SYNC(S_VS), .V_BACK(S_VB),
                     .CLK_DIV(3), .LEAD(0)) dutT (
        .Clk50(clock), .Reset_n(resetNS), .Enable(enableS), .PixEn(tPix), .HSync(tHs),
        .VSync(tVs), .Active(tAct), .Col(tCol), .Row(tRow), .LineStart(tLs),
        .FrameStart(tFs), .FrameCount(tFc));

    vga_timing_gen dutD (
        .Clk50(clock), .Reset_n(resetND), .Enable(enableD), .PixEn(dPix), .HSync(dHs),
        .VSync(dVs), .Active(dAct), .Col(dCol), .Row(dRow), .LineStart(dLs),
        .FrameStart(dFs), .FrameCount(dFc));

    assign outS = {sPix, sHs, sVs, sAct, sLs, sFs, sCol, sRow, sFc};
    assign outT = {tPix, tHs, tVs, tAct, tLs, tFs, tCol, tRow, tFc};
    assign outD = {dPix, dHs, dVs, dAct, dLs, dFs, dCol, dRow, dFc};

    // Expected outputs from k = enabled edges since the last clear: n pixels have elapsed,
    // outputs show pixel n-1 (one Clk50 late), and the fetch address is that pixel plus lead.
    function automatic outVec_t expectOut(input int k, input int fc, input int div, input int lead);
        outVec_t e;
        int n, n1, h, v, pos;
        e.frameCount = 16'(fc);
        if (k == 0) begin
            e.pixEn = 1'b0; e.hSync = 1'b1; e.vSync = 1'b1; e.active = 1'b0;
            e.lineStart = 1'b0; e.frameStart = 1'b0;
            e.col = 11'(lead % S_HT); e.row = 11'd0;
        end else begin
            n   = k / div;
            n1  = (k - 1) / div;
            h   = n1 % S_HT;
            v   = (n1 / S_HT) % S_VT;
            pos = n1 + lead;
            e.pixEn      = (k % div == 0);
            e.lineStart  = e.pixEn && (n % S_HT == 0);
            e.frameStart = e.pixEn && (n % S_FT == 0);
            e.active     = (h < S_HA) && (v < S_VA);
            e.hSync      = !((h >= S_HA + S_HF) && (h < S_HA + S_HF + S_HS));
            e.vSync      = !((v >= S_VA + S_VF) && (v < S_VA + S_VF + S_VS));
            e.col        = 11'(pos % S_HT);
            e.row        = 11'((pos / S_HT) % S_VT);
        end
        return e;
    endfunction

    function automatic bit frameEdge(input int k, input int div);
        return (k % div == 0) && ((k / div) % S_FT == 0);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the small instances at the falling edge, let one rising edge pass, return at the next falling edge
    task automatic applyStimulus(input logic en, input logic rstn);
        enableS = en;
        resetNS = rstn;
        @(posedge clock);
        @(negedge clock);
    endtask

    always @(posedge clock or negedge resetNS) begin
        if (!resetNS) begin
            kS <= 0; fcS <= 0; kT <= 0; fcT <= 0;
        end else if (!enableS) begin
            kS <= 0; kT <= 0;
        end else begin
            kS <= kS + 1;
            kT <= kT + 1;
            if (frameEdge(kS + 1, 1)) fcS <= fcS + 1;
            if (frameEdge(kT + 1, 3)) fcT <= fcT + 1;
        end
    end

    always @(negedge clock) begin
        if (modelOn) begin
            checkOutput("model_div1", 64'(outS), 64'(expectOut(kS, fcS, 1, 3)));
            checkOutput("model_div3", 64'(outT), 64'(expectOut(kT, fcT, 3, 0)));
        end
    end

    tableVec_t vecs[18];
    int fsTimes[4];
    int fsCnt, lsCnt, rowBad, rowWraps, prevRow, prevCol, found;
    int fall[2], nFall, lowW, actCnt, vsLow, pixCnt, lastPix, badInt, prevHs;

    initial begin
        vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd3,  11'd0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd4,  11'd0};
        vecs[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd5,  11'd0};
        vecs[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd6,  11'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd7,  11'd0};
        vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd8,  11'd0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd9,  11'd0};
        vecs[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd10, 11'd0};
        vecs[8]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd11, 11'd0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd12, 11'd0};
        vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd13, 11'd0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0,  11'd1};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 11'd1,  11'd1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 11'd2,  11'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd3,  11'd1};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd3,  11'd0};
        vecs[16] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 11'd3,  11'd0};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 11'd3,  11'd0};

        repeat (3) @(negedge clock);
        checkOutput("reset_default", 64'(outD), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd1, 11'd0, 16'd0}));
        checkOutput("reset_small", 64'(outS), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd3, 11'd0, 16'd0}));
        modelOn = 1'b1;

        // Vector table: Col sequence after reset, then an Enable drop and restart
        enableS = 1'b1;
        resetNS = 1'b1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i].en, 1'b1);
            checkOutput($sformatf("vec%0d", i),
                        64'({sPix, sAct, sHs, sLs, sCol, sRow}),
                        64'({vecs[i].pixEn, vecs[i].active, vecs[i].hSync, vecs[i].lineStart,
                             vecs[i].col, vecs[i].row}));
        end

        // Three small-mode frames from reset
        applyStimulus(1'b1, 1'b0);
        fsCnt = 0; lsCnt = 0; rowBad = 0; rowWraps = 0;
        prevRow = int'(sRow); prevCol = int'(sCol);
        for (int k = 1; k <= 3 * S_FT; k++) begin
            applyStimulus(1'b1, 1'b1);
            if (sFs) begin
                if (fsCnt < 4) fsTimes[fsCnt] = k;
                fsCnt++;
            end
            if (sLs) lsCnt++;
            if (int'(sRow) != prevRow) begin
                if (!(prevCol == 13 && sCol == 11'd0)) rowBad++;
                if (prevRow == 6 && sRow == 11'd0) rowWraps++;
            end
            prevRow = int'(sRow); prevCol = int'(sCol);
        end
        checkOutput("t3_framestart_count", 64'(fsCnt), 64'd3);
        checkOutput("t3_framestart_gap1", 64'(fsTimes[1] - fsTimes[0]), 64'd98);
        checkOutput("t3_framestart_gap2", 64'(fsTimes[2] - fsTimes[1]), 64'd98);
        checkOutput("t3_framecount", 64'(sFc), 64'd3);
        checkOutput("t3_linestart_count", 64'(lsCnt), 64'd21);
        checkOutput("t2_row_step_at_col_wrap", 64'(rowBad), 64'd0);
        checkOutput("t2_row_wraps", 64'(rowWraps), 64'd3);

        // Asynchronous reset while hsync is asserted
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (!sHs) found = 1;
        end
        checkOutput("t5_reached_hsync", 64'(found), 64'd1);
        #2 resetNS = 1'b0;
        #1;
        checkOutput("t5_async_reset_small", 64'(outS), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd3, 11'd0, 16'd0}));
        checkOutput("t5_async_reset_div3", 64'(outT), 64'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 11'd0, 11'd0, 16'd0}));
        @(negedge clock);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t5_restart", 64'({sPix, sLs, sFs, sCol, sFc}), 64'({1'b1, 1'b0, 1'b0, 11'd3, 16'd0}));

        // Enable dropped at HCnt=5, VCnt=2 for four cycles
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 2 * S_HT + 5; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("t4_hold%0d", i), 64'({sHs, sVs, sAct, sPix}), 64'({1'b1, 1'b1, 1'b0, 1'b0}));
        end
        applyStimulus(1'b1, 1'b1);
        checkOutput("t4_restart", 64'({sPix, sLs, sFs, sAct, sCol, sRow}),
                    64'({1'b1, 1'b0, 1'b0, 1'b1, 11'd3, 11'd0}));
        fsCnt = 0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 1'b1);
            if (sFs) fsCnt++;
        end
        checkOutput("t4_no_framestart", 64'(fsCnt), 64'd0);

        // CLK_DIV=3 instance: pixel strobe spacing and hsync width
        applyStimulus(1'b1, 1'b0);
        pixCnt = 0; lastPix = -1; badInt = 0; lowW = 0;
        for (int k = 1; k <= 60; k++) begin
            applyStimulus(1'b1, 1'b1);
            if (tPix) begin
                if (lastPix >= 0 && k - lastPix != 3) badInt++;
                lastPix = k;
                pixCnt++;
            end
            if (!tHs) lowW++;
        end
        checkOutput("t6_pixen_count", 64'(pixCnt), 64'd20);
        checkOutput("t6_pixen_spacing", 64'(badInt), 64'd0);
        checkOutput("t6_hsync_width", 64'(lowW), 64'd6);

        // Default 640x480 instance: two lines of horizontal timing
        resetND = 1'b1;
        enableD = 1'b1;
        nFall = 0; lowW = 0; actCnt = 0; vsLow = 0; pixCnt = 0; prevHs = 1;
        fall[0] = 0; fall[1] = 0;
        for (int k = 1; k <= 3200; k++) begin
            @(posedge clock);
            @(negedge clock);
            if (prevHs == 1 && !dHs) begin
                if (nFall < 2) fall[nFall] = k;
                nFall++;
            end
            if (nFall == 1 && !dHs) lowW++;
            if (nFall == 1 && dAct) actCnt++;
            if (!dVs) vsLow++;
            if (dPix) pixCnt++;
            prevHs = int'(dHs);
        end
        checkOutput("t1_hsync_period", 64'(fall[1] - fall[0]), 64'd1600);
        checkOutput("t1_hsync_low", 64'(lowW), 64'd192);
        checkOutput("t1_active_per_line", 64'(actCnt), 64'd1280);
        checkOutput("t1_vsync_idle", 64'(vsLow), 64'd0);
        checkOutput("t1_pixen_count", 64'(pixCnt), 64'd1600);

        // Random Enable drops and occasional resets against the reference model
        for (int i = 0; i < 3000; i++) begin
            applyStimulus(logic'($urandom_range(0, 99) >= 3), logic'($urandom_range(0, 499) != 0));
        end

        modelOn = 1'b0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
